// File: rtl/z_acc_rmw_ctrl_pkg.sv
// z_acc_rmw_ctrl_pkg: shared definitions for the Z accumulator read-modify-write sequencer.
//   - state_e     : FSM state encoding (IDLE=0, RD=1, CAP=2, WR=3, CLR=4)
//   - DefaultDw   : default data width of products, Z words and sums
//   - DefaultAw   : default Z memory address width
//   - DefaultDepth: default number of Z words cleared by the bulk-clear sequence
// These defaults are also used by the adder and the Z memory.
package z_acc_rmw_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StCap  = 3'd2,
        StWr   = 3'd3,
        StClr  = 3'd4
    } state_e;

    localparam int unsigned DefaultDw    = 16;
    localparam int unsigned DefaultAw    = 6;
    localparam int unsigned DefaultDepth = 64;

endpackage

// File: rtl/z_acc_rmw_ctrl.sv
// z_acc_rmw_ctrl: read-modify-write sequencer for the Z (accumulator) memory.
// Each accepted request reads Z[addr], presents the product and the Z word to an external
// combinational adder, then writes the sum back to Z[addr] (4 cycles per request).
// A bulk-clear sequence writes zero to Z[0..DEPTH-1], one word per cycle.
//
// Ports:
//   clk, rstn                  clock (posedge) and synchronous active-low reset
//   clear_i                    start bulk clear (sampled in IDLE only, beats req_valid_i)
//   req_valid_i/req_ready_o    accumulate request handshake
//   req_addr_i, req_multi_i    target Z address and product
//   multi_o, s_z_data_o        registered adder operands (updated only for the WR cycle)
//   result_i                   adder sum, passed through to mem_wdata_o
//   mem_rd_o/mem_we_o          Z memory read (1-cycle latency) / write enables
//   mem_addr_o, mem_wdata_o    shared Z memory address, write data
//   mem_data_i                 Z memory read data
//   busy_o                     state is not IDLE
//   done_o                     one-cycle pulse in the first IDLE cycle after a clear
//   op_cnt_o                   (Z_ACC_RMW_OPCNT_EN only) saturating count of WR cycles
//
// Optional feature macro: Z_ACC_RMW_OPCNT_EN.
module z_acc_rmw_ctrl
    import z_acc_rmw_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned AW    = DefaultAw,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_multi_i,
    output logic [DW-1:0] multi_o,
    output logic [DW-1:0] s_z_data_o,
    input  logic [DW-1:0] result_i,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
`ifdef Z_ACC_RMW_OPCNT_EN
    output logic [15:0]   op_cnt_o,
`endif
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] prod_q;
    logic [DW-1:0] z_q;
    logic [DW-1:0] multi_q;
    logic [AW-1:0] cnt_q;
    logic          done_q;

    logic accept;
    logic clr_start;

    assign clr_start = (state_q == StIdle) && clear_i;
    assign accept    = (state_q == StIdle) && !clear_i && req_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (clear_i) begin
                    state_d = StClr;
                end else if (req_valid_i) begin
                    state_d = StRd;
                end
            end
            StRd:  state_d = StCap;
            StCap: state_d = StWr;
            StWr:  state_d = StIdle;
            StClr: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            prod_q  <= '0;
            z_q     <= '0;
            multi_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StClr) && (cnt_q == LastAddr);
            if (accept) begin
                addr_q <= req_addr_i;
                prod_q <= req_multi_i;
            end
            // Both adder operands are loaded on the CAP->WR edge so they only change for WR.
            if (state_q == StCap) begin
                z_q     <= mem_data_i;
                multi_q <= prod_q;
            end
            if (clr_start) begin
                cnt_q <= '0;
            end else if (state_q == StClr) begin
                cnt_q <= cnt_q + AW'(1);
            end
        end
    end

    always_comb begin
        mem_rd_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            StRd: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = addr_q;
            end
            StCap: begin
                mem_addr_o = addr_q;
            end
            StWr: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = result_i;
            end
            StClr: begin
                mem_we_o   = 1'b1;
                mem_addr_o = cnt_q;
            end
            default: ;
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign multi_o     = multi_q;
    assign s_z_data_o  = z_q;

`ifdef Z_ACC_RMW_OPCNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_cnt_q <= '0;
        end else if (clr_start) begin
            op_cnt_q <= '0;
        end else if ((state_q == StWr) && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_cnt_o = op_cnt_q;
`endif

endmodule

// File: tb/tb_z_acc_rmw_ctrl.sv
// tb_z_acc_rmw_ctrl: self-checking bench for z_acc_rmw_ctrl with a Z memory model,
// an adder model, and a scoreboard of expected memory writes.
module tb_z_acc_rmw_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clear_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_multi_i = '0;
    logic [DW-1:0] multi_o;
    logic [DW-1:0] s_z_data_o;
    logic [DW-1:0] result_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic          busy_o;
    logic          done_o;
`ifdef Z_ACC_RMW_OPCNT_EN
    logic [15:0]   op_cnt_o;
`endif

    logic [DW-1:0] zmem  [DEPTH];
    logic [DW-1:0] ref_z [DEPTH];
    wr_t           exp_q [$];

    int checks = 0;
    int errors = 0;

    z_acc_rmw_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_multi_i (req_multi_i),
        .multi_o     (multi_o),
        .s_z_data_o  (s_z_data_o),
        .result_i    (result_i),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
`ifdef Z_ACC_RMW_OPCNT_EN
        .op_cnt_o    (op_cnt_o),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // External combinational adder, wraps at DW bits.
    assign result_i = multi_o + s_z_data_o;

    // Z memory model: synchronous write, read data one cycle after mem_rd_o.
    always @(posedge clk) begin
        if (mem_we_o === 1'b1) zmem[mem_addr_o] <= mem_wdata_o;
        if (mem_rd_o === 1'b1) mem_data_i <= zmem[mem_addr_o];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every write the DUT issues must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        wr_t e;
        if ((mem_rd_o === 1'b1) || (mem_we_o === 1'b1)) begin
            chk_eq("rd_we_exclusive", {31'd0, mem_rd_o & mem_we_o}, 32'd0);
        end
        if (mem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("wr_addr", 32'(mem_addr_o), 32'(e.addr));
                chk_eq("wr_data", 32'(mem_wdata_o), 32'(e.data));
            end
        end
    end

    // Called at a negedge in IDLE-wait; returns at the negedge of the RD cycle.
    task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] m, input bit track);
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk_eq("req_ready_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_multi_i = m;
        if (track) begin
            exp_q.push_back('{addr: a, data: ref_z[a] + m});
            ref_z[a] = ref_z[a] + m;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            zmem[i]  = '0;
            ref_z[i] = '0;
        end

        // Reset held for 3 cycles with a pending request.
        req_valid_i = 1'b1;
        req_addr_i  = 6'd1;
        req_multi_i = 16'h0009;
        repeat (3) @(negedge clk);
        chk_eq("rst_outputs",
               {busy_o, done_o, mem_rd_o, mem_we_o, 10'(mem_addr_o), 16'(mem_wdata_o)}, 32'd0);
        chk_eq("rst_operands", {multi_o, s_z_data_o}, 32'd0);
        req_valid_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk_eq("rel_ready", 32'(req_ready_o), 32'd1);
        chk_eq("rel_busy", 32'(busy_o), 32'd0);

        // Single accumulate: Z[5]=0x10 + 3.
        zmem[5]  = 16'h0010;
        ref_z[5] = 16'h0010;
        do_req(6'd5, 16'h0003, 1'b1);
        chk_eq("t1_rd", 32'(mem_rd_o), 32'd1);
        chk_eq("t1_addr", 32'(mem_addr_o), 32'd5);
        chk_eq("t1_busy", 32'(busy_o), 32'd1);
        chk_eq("t1_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        chk_eq("t2_busy_nowr", {busy_o, mem_rd_o, mem_we_o}, 32'b100);
        @(negedge clk);
        chk_eq("t3_we", 32'(mem_we_o), 32'd1);
        chk_eq("t3_addr", 32'(mem_addr_o), 32'd5);
        chk_eq("t3_wdata", 32'(mem_wdata_o), 32'h0013);
        chk_eq("t3_multi", 32'(multi_o), 32'h0003);
        chk_eq("t3_sz", 32'(s_z_data_o), 32'h0010);
        chk_eq("t3_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk_eq("t4_idle", {busy_o, req_ready_o}, 32'b01);
        chk_eq("t4_multi_hold", 32'(multi_o), 32'h0003);

        // Back-to-back requests to the same address.
        for (int k = 0; k < 3; k++) begin
            do_req(6'd2, 16'h0001, 1'b1);
            for (int c = 0; c < 3; c++) begin
                chk_eq("b2b_ready_low", 32'(req_ready_o), 32'd0);
                @(negedge clk);
            end
            chk_eq("b2b_ready_high", 32'(req_ready_o), 32'd1);
        end
        chk_eq("b2b_final_z2", 32'(zmem[2]), 32'd3);

        // Overflow wraps modulo 2**DW.
        zmem[7]  = 16'hFFFF;
        ref_z[7] = 16'hFFFF;
        do_req(6'd7, 16'h0002, 1'b1);
        repeat (3) @(negedge clk);
        chk_eq("wrap_z7", 32'(zmem[7]), 32'h0001);

        // Clear beats a simultaneous request; request is accepted afterwards.
        zmem[9]   = 16'h1234;
        ref_z[9]  = 16'h1234;
        zmem[63]  = 16'hAAAA;
        ref_z[63] = 16'hAAAA;
        clear_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 6'd9;
        req_multi_i = 16'h0005;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{addr: AW'(i), data: '0});
            ref_z[i] = '0;
        end
        @(negedge clk);
        clear_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_eq("clr_state", {mem_we_o, req_ready_o, done_o, busy_o}, 32'b1001);
            @(negedge clk);
        end
        chk_eq("clr_done", 32'(done_o), 32'd1);
        chk_eq("clr_ready", 32'(req_ready_o), 32'd1);
        chk_eq("clr_we_off", 32'(mem_we_o), 32'd0);
        exp_q.push_back('{addr: 6'd9, data: 16'h0005});
        ref_z[9] = 16'h0005;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk_eq("clr_done_once", 32'(done_o), 32'd0);
        chk_eq("post_clr_rd", {mem_rd_o, 10'(mem_addr_o)}, {1'b1, 10'd9});
        repeat (3) @(negedge clk);
        chk_eq("post_clr_z9", 32'(zmem[9]), 32'h0005);
        chk_eq("post_clr_z63", 32'(zmem[63]), 32'd0);
`ifdef Z_ACC_RMW_OPCNT_EN
        chk_eq("op_cnt_after_clr", 32'(op_cnt_o), 32'd1);
`endif

        // Reset during CAP aborts the operation without a write.
        zmem[11]  = 16'h0040;
        ref_z[11] = 16'h0040;
        do_req(6'd11, 16'h0007, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_eq("midrst_idle", {busy_o, mem_we_o, req_ready_o}, 32'b001);
        chk_eq("midrst_operands", {multi_o, s_z_data_o}, 32'd0);
`ifdef Z_ACC_RMW_OPCNT_EN
        chk_eq("op_cnt_reset", 32'(op_cnt_o), 32'd0);
`endif
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_eq("midrst_no_we", 32'(mem_we_o), 32'd0);
        end
        chk_eq("midrst_ready", 32'(req_ready_o), 32'd1);
        chk_eq("midrst_z11", 32'(zmem[11]), 32'h0040);

        chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
